dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port 256x16 data memory between the CPU MEM stage (port 0) and the debug/loader DMA port (port 1). It accepts one request per cycle, registers the winning command, drives the memory in the following cycle, and returns read data with a per-port valid pulse. It sits between the pipeline/debug logic and the data memory and is the only block driving the memory's enable, write, address and data inputs.

## Interface
- ADDR_W, 8, address width; memory depth is 2^ADDR_W
- DATA_W, 16, data width
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins
- clka  in  1  clock; all state updates on posedge
- rst  in  1  reset; one clock, synchronous, active-high
- p0_req / p1_req  in  1  request valid; command fields valid while high
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_gnt / p1_gnt  out  1  combinational accept; transfer occurs in a cycle with req&gnt
- p0_stall  out  1  p0_req & ~p0_gnt; stalls the pipeline
- p0_rdata / p1_rdata  out  DATA_W  registered read data, held until the port's next read returns
- p0_rvalid / p1_rvalid  out  1  one-cycle pulse, rdata valid
- mem_ena, mem_wea  out  1  memory enable / write enable
- mem_addra  out  ADDR_W  memory address
- mem_dina  out  DATA_W  memory write data
- mem_douta  in  DATA_W  memory read data; combinational from mem_addra

## Operation
- Stage A (arbitrate, cycle N): winner chosen among asserted reqs; at most one gnt high per cycle; gnt forced 0 while rst high.
- Round-robin (FIXED_PRIO=0): single request wins outright; both requesting -> port not granted most recently wins. last_grant updates only on an accepted transfer. Reset value of last_grant = 1 (port 0 wins first tie).
- FIXED_PRIO=1: port 0 wins every tie; port 1 may starve (intended).
- At posedge ending N: cmd_valid<=1, cmd_port, cmd_we, cmd_addr, cmd_wdata latched from winner; no winner -> cmd_valid<=0.
- Stage B (memory, cycle N+1): mem_ena = cmd_valid & ~rst; mem_wea = cmd_valid & cmd_we & ~rst; mem_addra = cmd_addr; mem_dina = cmd_wdata. Memory write commits at posedge ending N+1.
- Read: at posedge ending N+1, mem_douta captured into rdata of cmd_port; that port's rvalid=1 during N+2 only. Other port's rdata unchanged. Writes produce no rvalid.
- Requester may change command fields or drop req in the cycle after a req&gnt cycle; without gnt it must hold fields stable.
- Ordering: commands execute in accept order; write accepted at N followed by read of same address accepted at N+1 returns the new data (write commits before read stage).
- Reset (any cycle, incl. mid-operation): at posedge with rst=1, cmd_valid, rvalids, rdatas, last_grant reset; an in-flight command in stage B during the rst cycle is dropped (mem_ena gated) and produces no rvalid.

## Timing
- Reset values: p0/p1_gnt 0, p0_stall 0 while no req, p0/p1_rdata 0, p0/p1_rvalid 0, mem_ena 0, mem_wea 0, mem_addra 0, mem_dina 0.
- Accept latency 0 cycles (gnt combinational with req, same cycle).
- Read latency: req&gnt at cycle N -> rvalid and rdata at cycle N+2.
- Write commit: end of N+1.
- Throughput: one access per cycle total; both ports continuously requesting with FIXED_PRIO=0 -> strict alternation 0,1,0,1...
- p0_stall purely combinational from p0_req and p0_gnt.

## Test plan
- Memory preloaded mem[1]=9, mem[2]=6; p0 read addr 1 at cycle N -> p0_gnt=1 at N, mem_ena=1/mem_addra=1 at N+1, p0_rvalid=1 with p0_rdata=9 at N+2, p1_rvalid stays 0.
- p0 write addr 5 data 0x1234 at N, p0 read addr 5 at N+1 (back-to-back) -> mem_wea=1 at N+1, p0_rdata=0x1234 at N+3.
- Both ports read (p0 addr 1, p1 addr 2) held high 4 cycles, FIXED_PRIO=0 -> gnt order p0,p1,p0,p1; p0_stall=1 in p1-granted cycles; rdata values 9 and 6 alternate.
- FIXED_PRIO=1, both requesting 3 cycles -> p0_gnt=1 every cycle, p1_gnt=0, p1 granted the cycle after p0_req drops.
- p1 write addr 3 data 0xBEEF accepted at N, rst=1 at N+1 -> mem_ena=0 and mem_wea=0 at N+1, mem[3] remains 0, all outputs at reset values at N+2.
- Idle then single p1 read after reset with both subsequently requesting -> first tie won by p0 (last_grant reset = 1).

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the CPU MEM stage (port 0) and
// the debug/loader DMA port (port 1). One command is accepted per cycle in
// stage A, registered, and presented to the memory in stage B. Read data is
// captured at the end of stage B and returned with a one-cycle valid pulse
// on the owning port.
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clka,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_stall,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,

    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    // Arbitration state: 1 means port 1 held the most recent accepted transfer.
    logic              r_last_grant;

    // Stage B command register.
    logic              r_cmd_valid;
    logic              r_cmd_port;
    logic              r_cmd_we;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;

    // Read return registers.
    logic              r_p0_rvalid;
    logic              r_p1_rvalid;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_accept;
    logic              w_rd_ret;

    // Stage A: choose at most one winner; nothing is granted during reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (p0_req && p1_req) begin
                // Tie: fixed priority favours port 0, otherwise the port
                // that did not win the previous transfer goes next.
                if ((FIXED_PRIO != 0) || r_last_grant) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = p0_req;
                w_gnt1 = p1_req;
            end
        end
    end

    assign w_accept = w_gnt0 | w_gnt1;

    // Register the winning command and remember who won for round-robin.
    always_ff @(posedge clka) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_cmd_valid  <= 1'b0;
            r_cmd_port   <= 1'b0;
            r_cmd_we     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
        end else begin
            r_cmd_valid <= w_accept;
            if (w_accept) begin
                r_last_grant <= w_gnt1;
                r_cmd_port   <= w_gnt1;
                r_cmd_we     <= w_gnt1 ? p1_we    : p0_we;
                r_cmd_addr   <= w_gnt1 ? p1_addr  : p0_addr;
                r_cmd_wdata  <= w_gnt1 ? p1_wdata : p0_wdata;
            end
        end
    end

    // A stage B read is returning data this cycle. Reset is handled by the
    // register branch below, so a read in flight during reset is dropped.
    assign w_rd_ret = r_cmd_valid & ~r_cmd_we;

    // Capture read data into the owning port and pulse its valid for one cycle.
    always_ff @(posedge clka) begin
        if (rst) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= w_rd_ret & ~r_cmd_port;
            r_p1_rvalid <= w_rd_ret &  r_cmd_port;
            if (w_rd_ret && !r_cmd_port) begin
                r_p0_rdata <= mem_douta;
            end
            if (w_rd_ret && r_cmd_port) begin
                r_p1_rdata <= mem_douta;
            end
        end
    end

    assign p0_gnt    = w_gnt0;
    assign p1_gnt    = w_gnt1;
    assign p0_stall  = p0_req & ~w_gnt0;

    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

    // Enables are gated by reset so a command caught mid-flight never commits.
    assign mem_ena   = r_cmd_valid & ~rst;
    assign mem_wea   = r_cmd_valid & r_cmd_we & ~rst;
    assign mem_addra = r_cmd_addr;
    assign mem_dina  = r_cmd_wdata;

endmodule
